// File: rtl/victim_cache_if.sv
// victim_cache_if: L1-side lookup/swap, evict insert and
// memory write-back channels of the victim cache.
interface victim_cache_if #(
  parameter int ENTRIES = 4,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128
);
  localparam int CNT_W = $clog2(ENTRIES) + 1;

  logic              lookup_valid_i;
  logic [ADDR_W-1:0] lookup_addr_i;
  logic              swap_valid_o;
  logic [ADDR_W-1:0] swap_addr_o;
  logic [LINE_W-1:0] swap_data_o;
  logic              swap_dirty_o;
  logic              lookup_miss_o;
  logic              evict_valid_i;
  logic [ADDR_W-1:0] evict_addr_i;
  logic [LINE_W-1:0] evict_data_i;
  logic              evict_dirty_i;
  logic              evict_ready_o;
  logic              wb_valid_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [LINE_W-1:0] wb_data_o;
  logic              wb_ready_i;
  logic [CNT_W-1:0]  occupancy_o;
  logic [31:0]       no_lookup_o;
  logic [31:0]       no_hit_o;

  modport slave (
    input  lookup_valid_i, lookup_addr_i,
    input  evict_valid_i, evict_addr_i,
    input  evict_data_i, evict_dirty_i,
    input  wb_ready_i,
    output swap_valid_o, swap_addr_o,
    output swap_data_o, swap_dirty_o,
    output lookup_miss_o, evict_ready_o,
    output wb_valid_o, wb_addr_o, wb_data_o,
    output occupancy_o, no_lookup_o, no_hit_o
  );

  modport master (
    output lookup_valid_i, lookup_addr_i,
    output evict_valid_i, evict_addr_i,
    output evict_data_i, evict_dirty_i,
    output wb_ready_i,
    input  swap_valid_o, swap_addr_o,
    input  swap_data_o, swap_dirty_o,
    input  lookup_miss_o, evict_ready_o,
    input  wb_valid_o, wb_addr_o, wb_data_o,
    input  occupancy_o, no_lookup_o, no_hit_o
  );
endinterface

// File: rtl/victim_cache.sv
// victim_cache: fully-associative victim store beside the L1 FSM,
// swap-on-hit lookup, FIFO replacement, dirty write-back.
module victim_cache #(
  parameter int ENTRIES  = 4,
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  victim_cache_if.slave vc
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {IDLE, WB_PEND} wb_state_e;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] dirty_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [LINE_W-1:0]  data_q [ENTRIES];
  logic [IDX_W-1:0]   ptr_q;

  wb_state_e         wb_state_q;
  logic              wb_valid_q;
  logic              evict_ready_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [LINE_W-1:0] wb_data_q;

  logic              swap_valid_q;
  logic [ADDR_W-1:0] swap_addr_q;
  logic [LINE_W-1:0] swap_data_q;
  logic              swap_dirty_q;
  logic              miss_q;
  logic [CNT_W-1:0]  occ_q;
  logic [31:0]       n_lookup_q;
  logic [31:0]       n_hit_q;

  logic [TAG_W-1:0]   lk_tag;
  logic [TAG_W-1:0]   ev_tag;
  logic [ENTRIES-1:0] hit_vec;
  logic [IDX_W-1:0]   hit_idx;
  logic               lk_hit;
  logic               ins;
  logic               match;
  logic [IDX_W-1:0]   match_idx;
  logic               free;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   slot;
  logic               replace;
  logic               spill;
  logic [ENTRIES-1:0] valid_d;
  logic [CNT_W-1:0]   occ_d;
  logic               unused_ok;

  assign lk_tag = vc.lookup_addr_i[ADDR_W-1:OFFSET_W];
  assign ev_tag = vc.evict_addr_i[ADDR_W-1:OFFSET_W];
  assign unused_ok = ^{vc.lookup_addr_i[OFFSET_W-1:0],
                       vc.evict_addr_i[OFFSET_W-1:0]};

  // Lookup tag match; the one-per-tag invariant means one hit at most
  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (vc.lookup_valid_i && valid_q[i] &&
          tag_q[i] == lk_tag) begin
        hit_vec[i] = 1'b1;
        hit_idx    = IDX_W'(i);
      end
    end
  end

  assign lk_hit = |hit_vec;

  // Insert slot: same tag, else lowest free (hit-freed counts), else FIFO
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    free      = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == ev_tag) begin
        match     = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i] || hit_vec[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign ins     = vc.evict_valid_i & evict_ready_q;
  assign slot    = match ? match_idx :
                   free  ? free_idx  : ptr_q;
  assign replace = ins & ~match & ~free;
  assign spill   = replace & dirty_q[ptr_q];

  // Post-edge valid set and its population count
  always_comb begin
    valid_d = valid_q & ~hit_vec;
    if (ins) valid_d[slot] = 1'b1;
    occ_d = '0;
    for (int i = 0; i < ENTRIES; i++)
      occ_d = occ_d + CNT_W'(valid_d[i]);
  end

  // Entry flags and FIFO pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (ins)
        dirty_q[slot] <= (match & dirty_q[slot]) |
                         vc.evict_dirty_i;
      if (replace) ptr_q <= ptr_q + 1'b1;
    end
  end

  // Tag and line storage, written on accepted insert
  always_ff @(posedge clk_i) begin
    if (ins) begin
      tag_q[slot]  <= ev_tag;
      data_q[slot] <= vc.evict_data_i;
    end
  end

  // Swap/miss response, counters and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      swap_valid_q <= 1'b0;
      swap_addr_q  <= '0;
      swap_data_q  <= '0;
      swap_dirty_q <= 1'b0;
      miss_q       <= 1'b0;
      occ_q        <= '0;
      n_lookup_q   <= '0;
      n_hit_q      <= '0;
    end else begin
      swap_valid_q <= lk_hit;
      swap_addr_q  <= lk_hit ?
        {tag_q[hit_idx], {OFFSET_W{1'b0}}} : '0;
      swap_data_q  <= lk_hit ? data_q[hit_idx] : '0;
      swap_dirty_q <= lk_hit & dirty_q[hit_idx];
      miss_q       <= vc.lookup_valid_i & ~lk_hit;
      occ_q        <= occ_d;
      if (vc.lookup_valid_i)
        n_lookup_q <= n_lookup_q + 32'd1;
      if (lk_hit)
        n_hit_q <= n_hit_q + 32'd1;
    end
  end

  // Write-back FSM holding one displaced dirty line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_state_q    <= IDLE;
      wb_valid_q    <= 1'b0;
      evict_ready_q <= 1'b1;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
    end else begin
      unique case (wb_state_q)
        IDLE: begin
          if (spill) begin
            wb_state_q    <= WB_PEND;
            wb_valid_q    <= 1'b1;
            evict_ready_q <= 1'b0;
            wb_addr_q     <=
              {tag_q[ptr_q], {OFFSET_W{1'b0}}};
            wb_data_q     <= data_q[ptr_q];
          end
        end
        WB_PEND: begin
          if (vc.wb_ready_i) begin
            wb_state_q    <= IDLE;
            wb_valid_q    <= 1'b0;
            evict_ready_q <= 1'b1;
            wb_addr_q     <= '0;
            wb_data_q     <= '0;
          end
        end
        default: wb_state_q <= IDLE;
      endcase
    end
  end

  assign vc.swap_valid_o  = swap_valid_q;
  assign vc.swap_addr_o   = swap_addr_q;
  assign vc.swap_data_o   = swap_data_q;
  assign vc.swap_dirty_o  = swap_dirty_q;
  assign vc.lookup_miss_o = miss_q;
  assign vc.evict_ready_o = evict_ready_q;
  assign vc.wb_valid_o    = wb_valid_q;
  assign vc.wb_addr_o     = wb_addr_q;
  assign vc.wb_data_o     = wb_data_q;
  assign vc.occupancy_o   = occ_q;
  assign vc.no_lookup_o   = n_lookup_q;
  assign vc.no_hit_o      = n_hit_q;
endmodule

// File: tb/tb_victim_cache.sv
// tb_victim_cache: directed scenarios plus random traffic
// checked against a behavioural victim-cache model.
module tb_victim_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  victim_cache_if #(
    .ENTRIES(4), .ADDR_W(32), .LINE_W(128)
  ) vif ();

  victim_cache #(
    .ENTRIES(4), .ADDR_W(32),
    .LINE_W(128), .OFFSET_W(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .vc(vif)
  );

  // Behavioural model: a list of lines with FIFO victim order
  bit           m_v   [4];
  logic [27:0]  m_t   [4];
  logic [127:0] m_d   [4];
  bit           m_dt  [4];
  int           m_ptr;
  bit           m_pend;
  logic [31:0]  m_wa;
  logic [127:0] m_wd;
  logic [31:0]  m_nl, m_nh;
  bit           e_sv, e_sdt, e_miss;
  logic [31:0]  e_sa;
  logic [127:0] e_sd;
  int           e_occ;

  function automatic logic [127:0] line_of(
    input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, a + 32'h1234_0000};
  endfunction

  function automatic void model_step();
    int hit = -1;
    int slot = -1;
    logic [27:0] lt = vif.lookup_addr_i[31:4];
    logic [27:0] et = vif.evict_addr_i[31:4];
    bit acc;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_v[i] = 0; m_dt[i] = 0;
      end
      m_ptr = 0; m_pend = 0; m_wa = 0; m_wd = 0;
      m_nl = 0; m_nh = 0;
      e_sv = 0; e_sa = 0; e_sd = 0; e_sdt = 0;
      e_miss = 0; e_occ = 0;
      return;
    end
    if (vif.lookup_valid_i) begin
      m_nl++;
      for (int i = 0; i < 4; i++)
        if (m_v[i] && m_t[i] == lt) hit = i;
    end
    e_sv   = (hit >= 0);
    e_sa   = e_sv ? {m_t[hit], 4'h0} : 32'h0;
    e_sd   = e_sv ? m_d[hit] : 128'h0;
    e_sdt  = e_sv ? m_dt[hit] : 1'b0;
    e_miss = vif.lookup_valid_i && !e_sv;
    if (e_sv) m_nh++;
    acc = vif.evict_valid_i && !m_pend;
    if (m_pend && vif.wb_ready_i) begin
      m_pend = 0; m_wa = 0; m_wd = 0;
    end
    if (e_sv) m_v[hit] = 0;
    if (acc) begin
      bit keep = 0;
      for (int i = 0; i < 4; i++)
        if (m_v[i] && m_t[i] == et) begin
          slot = i; keep = m_dt[i];
        end
      if (slot < 0)
        for (int i = 3; i >= 0; i--)
          if (!m_v[i]) slot = i;
      if (slot < 0) begin
        slot = m_ptr;
        if (m_dt[slot]) begin
          m_pend = 1;
          m_wa = {m_t[slot], 4'h0};
          m_wd = m_d[slot];
        end
        m_ptr = (m_ptr + 1) % 4;
      end
      m_v[slot]  = 1;
      m_t[slot]  = et;
      m_d[slot]  = vif.evict_data_i;
      m_dt[slot] = keep | vif.evict_dirty_i;
    end
    e_occ = 0;
    for (int i = 0; i < 4; i++) e_occ += m_v[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    vif.lookup_valid_i = 0;
    vif.lookup_addr_i  = 0;
    vif.evict_valid_i  = 0;
    vif.evict_addr_i   = 0;
    vif.evict_data_i   = 0;
    vif.evict_dirty_i  = 0;
    vif.wb_ready_i     = 0;
  endtask

  task automatic set_ev(input logic [31:0] a,
                        input bit dt);
    vif.evict_valid_i = 1;
    vif.evict_addr_i  = a;
    vif.evict_data_i  = line_of(a);
    vif.evict_dirty_i = dt;
  endtask

  task automatic ins(input logic [31:0] a,
                     input bit dt);
    set_ev(a, dt);
    tick();
    idle_in();
  endtask

  task automatic look(input logic [31:0] a);
    vif.lookup_valid_i = 1;
    vif.lookup_addr_i  = a;
    tick();
    idle_in();
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (vif.swap_valid_o !== 0 ||
        vif.lookup_miss_o !== 0) begin
      errors++;
      $display("FAIL reset_swap: got sv=%b miss=%b need 0 0",
               vif.swap_valid_o, vif.lookup_miss_o);
    end
    checks++;
    if (vif.evict_ready_o !== 1 ||
        vif.wb_valid_o !== 0) begin
      errors++;
      $display("FAIL reset_wb: got rdy=%b wbv=%b need 1 0",
               vif.evict_ready_o, vif.wb_valid_o);
    end
    checks++;
    if (vif.occupancy_o !== 0 || vif.no_lookup_o !== 0 ||
        vif.no_hit_o !== 0) begin
      errors++;
      $display("FAIL reset_cnt: got occ=%0d nl=%0d nh=%0d need 0",
               vif.occupancy_o, vif.no_lookup_o, vif.no_hit_o);
    end
  endtask

  task automatic test_hit();
    do_reset();
    ins(32'h1000, 0);
    ins(32'h2000, 0);
    checks++;
    if (vif.occupancy_o !== 2) begin
      errors++;
      $display("FAIL hit_occ2: got %0d need 2",
               vif.occupancy_o);
    end
    look(32'h2004);
    checks++;
    if (vif.swap_valid_o !== 1 ||
        vif.swap_addr_o !== 32'h2000 ||
        vif.swap_dirty_o !== 0) begin
      errors++;
      $display("FAIL hit_swap: got v=%b a=%h d=%b need 1 2000 0",
               vif.swap_valid_o, vif.swap_addr_o,
               vif.swap_dirty_o);
    end
    checks++;
    if (vif.swap_data_o !== line_of(32'h2000)) begin
      errors++;
      $display("FAIL hit_data: got %h need %h",
               vif.swap_data_o, line_of(32'h2000));
    end
    checks++;
    if (vif.occupancy_o !== 1 || vif.no_hit_o !== 1 ||
        vif.no_lookup_o !== 1) begin
      errors++;
      $display("FAIL hit_cnt: got occ=%0d nh=%0d nl=%0d need 1 1 1",
               vif.occupancy_o, vif.no_hit_o, vif.no_lookup_o);
    end
    tick();
    checks++;
    if (vif.swap_valid_o !== 0 || vif.swap_addr_o !== 0) begin
      errors++;
      $display("FAIL hit_pulse: got v=%b a=%h need 0 0",
               vif.swap_valid_o, vif.swap_addr_o);
    end
  endtask

  task automatic test_miss();
    do_reset();
    ins(32'h1000, 1);
    look(32'h3000);
    checks++;
    if (vif.lookup_miss_o !== 1 || vif.swap_valid_o !== 0 ||
        vif.swap_data_o !== 0) begin
      errors++;
      $display("FAIL miss_resp: got m=%b v=%b need 1 0",
               vif.lookup_miss_o, vif.swap_valid_o);
    end
    checks++;
    if (vif.no_lookup_o !== 1 || vif.no_hit_o !== 0) begin
      errors++;
      $display("FAIL miss_cnt: got nl=%0d nh=%0d need 1 0",
               vif.no_lookup_o, vif.no_hit_o);
    end
    tick();
    checks++;
    if (vif.lookup_miss_o !== 0) begin
      errors++;
      $display("FAIL miss_pulse: got %b need 0",
               vif.lookup_miss_o);
    end
  endtask

  task automatic test_writeback();
    do_reset();
    ins(32'h1000, 1);
    ins(32'h2000, 0);
    ins(32'h3000, 0);
    ins(32'h4000, 0);
    checks++;
    if (vif.occupancy_o !== 4) begin
      errors++;
      $display("FAIL wb_full: got %0d need 4",
               vif.occupancy_o);
    end
    ins(32'h5000, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (vif.wb_valid_o !== 1 ||
          vif.wb_addr_o !== 32'h1000 ||
          vif.wb_data_o !== line_of(32'h1000) ||
          vif.evict_ready_o !== 0) begin
        errors++;
        $display("FAIL wb_hold%0d: got v=%b a=%h r=%b need 1 1000 0",
                 k, vif.wb_valid_o, vif.wb_addr_o,
                 vif.evict_ready_o);
      end
      if (k < 3) tick();
    end
    vif.wb_ready_i = 1;
    tick();
    vif.wb_ready_i = 0;
    checks++;
    if (vif.wb_valid_o !== 0 || vif.evict_ready_o !== 1 ||
        vif.occupancy_o !== 4) begin
      errors++;
      $display("FAIL wb_done: got v=%b r=%b occ=%0d need 0 1 4",
               vif.wb_valid_o, vif.evict_ready_o,
               vif.occupancy_o);
    end
    ins(32'h6000, 0);
    look(32'h2000);
    checks++;
    if (vif.lookup_miss_o !== 1 || vif.wb_valid_o !== 0) begin
      errors++;
      $display("FAIL wb_ptr1: got m=%b wbv=%b need 1 0",
               vif.lookup_miss_o, vif.wb_valid_o);
    end
    look(32'h3000);
    checks++;
    if (vif.swap_valid_o !== 1 ||
        vif.swap_addr_o !== 32'h3000) begin
      errors++;
      $display("FAIL wb_keep: got v=%b a=%h need 1 3000",
               vif.swap_valid_o, vif.swap_addr_o);
    end
  endtask

  task automatic test_clean_replace();
    do_reset();
    ins(32'h1000, 0);
    ins(32'h2000, 0);
    ins(32'h3000, 0);
    ins(32'h4000, 0);
    ins(32'h6000, 0);
    checks++;
    if (vif.wb_valid_o !== 0 || vif.occupancy_o !== 4 ||
        vif.evict_ready_o !== 1) begin
      errors++;
      $display("FAIL clean_rep: got wbv=%b occ=%0d r=%b need 0 4 1",
               vif.wb_valid_o, vif.occupancy_o,
               vif.evict_ready_o);
    end
    look(32'h1000);
    checks++;
    if (vif.lookup_miss_o !== 1) begin
      errors++;
      $display("FAIL clean_gone: got miss=%b need 1",
               vif.lookup_miss_o);
    end
    look(32'h600C);
    checks++;
    if (vif.swap_valid_o !== 1 ||
        vif.swap_addr_o !== 32'h6000 ||
        vif.swap_data_o !== line_of(32'h6000)) begin
      errors++;
      $display("FAIL clean_new: got v=%b a=%h need 1 6000",
               vif.swap_valid_o, vif.swap_addr_o);
    end
  endtask

  task automatic test_hit_plus_insert();
    do_reset();
    ins(32'h1000, 1);
    ins(32'h2000, 0);
    ins(32'h3000, 0);
    ins(32'h4000, 0);
    vif.lookup_valid_i = 1;
    vif.lookup_addr_i  = 32'h3008;
    set_ev(32'h7000, 0);
    tick();
    idle_in();
    checks++;
    if (vif.swap_valid_o !== 1 ||
        vif.swap_addr_o !== 32'h3000 ||
        vif.wb_valid_o !== 0 ||
        vif.occupancy_o !== 4) begin
      errors++;
      $display("FAIL hpi_swap: got v=%b a=%h wbv=%b occ=%0d need 1 3000 0 4",
               vif.swap_valid_o, vif.swap_addr_o,
               vif.wb_valid_o, vif.occupancy_o);
    end
    ins(32'h8000, 0);
    checks++;
    if (vif.wb_valid_o !== 1 ||
        vif.wb_addr_o !== 32'h1000) begin
      errors++;
      $display("FAIL hpi_ptr: got wbv=%b a=%h need 1 1000",
               vif.wb_valid_o, vif.wb_addr_o);
    end
    vif.wb_ready_i = 1;
    tick();
    idle_in();
    look(32'h7000);
    checks++;
    if (vif.swap_valid_o !== 1 ||
        vif.swap_addr_o !== 32'h7000) begin
      errors++;
      $display("FAIL hpi_new: got v=%b a=%h need 1 7000",
               vif.swap_valid_o, vif.swap_addr_o);
    end
  endtask

  task automatic test_reset_in_wb();
    do_reset();
    ins(32'h1000, 1);
    ins(32'h2000, 1);
    ins(32'h3000, 1);
    ins(32'h4000, 1);
    ins(32'h5000, 1);
    look(32'h2000);
    checks++;
    if (vif.swap_valid_o !== 1 || vif.swap_dirty_o !== 1 ||
        vif.wb_valid_o !== 1 || vif.evict_ready_o !== 0) begin
      errors++;
      $display("FAIL rwb_serve: got v=%b d=%b wbv=%b r=%b need 1 1 1 0",
               vif.swap_valid_o, vif.swap_dirty_o,
               vif.wb_valid_o, vif.evict_ready_o);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (vif.wb_valid_o !== 0 || vif.occupancy_o !== 0 ||
        vif.evict_ready_o !== 1 || vif.no_lookup_o !== 0 ||
        vif.no_hit_o !== 0 || vif.swap_valid_o !== 0) begin
      errors++;
      $display("FAIL rwb_reset: got wbv=%b occ=%0d r=%b nl=%0d nh=%0d",
               vif.wb_valid_o, vif.occupancy_o,
               vif.evict_ready_o, vif.no_lookup_o,
               vif.no_hit_o);
    end
    tick();
    checks++;
    if (vif.wb_valid_o !== 0 || vif.wb_addr_o !== 0) begin
      errors++;
      $display("FAIL rwb_drop: got wbv=%b a=%h need 0 0",
               vif.wb_valid_o, vif.wb_addr_o);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] la, ea;
      la = ($urandom_range(1, 8) << 12) |
           $urandom_range(0, 15);
      ea = ($urandom_range(1, 8) << 12) |
           $urandom_range(0, 15);
      vif.lookup_valid_i = $urandom_range(0, 1);
      vif.lookup_addr_i  = la;
      set_ev(ea, $urandom_range(0, 1));
      vif.evict_data_i   = {$urandom, $urandom,
                            $urandom, $urandom};
      vif.evict_valid_i  = ($urandom_range(0, 1) == 1);
      if (vif.lookup_valid_i &&
          la[31:4] == ea[31:4])
        vif.evict_valid_i = 0;
      vif.wb_ready_i = ($urandom_range(0, 2) == 0);
      tick();
      bad = 0;
      checks++;
      if (vif.swap_valid_o !== e_sv ||
          vif.swap_addr_o !== e_sa ||
          vif.swap_dirty_o !== e_sdt ||
          vif.swap_data_o !== e_sd ||
          vif.lookup_miss_o !== e_miss) begin
        errors++; bad = 1;
        $display("FAIL rnd_swap c=%0d: got v=%b a=%h d=%b m=%b need %b %h %b %b",
                 c, vif.swap_valid_o, vif.swap_addr_o,
                 vif.swap_dirty_o, vif.lookup_miss_o,
                 e_sv, e_sa, e_sdt, e_miss);
      end
      checks++;
      if (vif.wb_valid_o !== m_pend ||
          vif.evict_ready_o !== !m_pend ||
          vif.wb_addr_o !== m_wa ||
          vif.wb_data_o !== m_wd) begin
        errors++; bad = 1;
        $display("FAIL rnd_wb c=%0d: got v=%b r=%b a=%h need %b %b %h",
                 c, vif.wb_valid_o, vif.evict_ready_o,
                 vif.wb_addr_o, m_pend, !m_pend, m_wa);
      end
      checks++;
      if (vif.occupancy_o !== 3'(e_occ) ||
          vif.no_lookup_o !== m_nl ||
          vif.no_hit_o !== m_nh) begin
        errors++; bad = 1;
        $display("FAIL rnd_cnt c=%0d: got occ=%0d nl=%0d nh=%0d need %0d %0d %0d",
                 c, vif.occupancy_o, vif.no_lookup_o,
                 vif.no_hit_o, e_occ, m_nl, m_nh);
      end
      if (bad != 0 && errors > 20) break;
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_hit();
    test_miss();
    test_writeback();
    test_clean_replace();
    test_hit_plus_insert();
    test_reset_in_wb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/victim_cache.md
Name: victim_cache

Overview:
- Small fully-associative victim cache that sits directly beside the L1 cache FSM.
- It consumes the evicted line the FSM produces on a miss with a valid victim.
- It answers the FSM's miss lookup with a one-cycle swap response carrying the matching line, which the FSM then writes into L1.
- When a dirty entry is displaced, it writes that line back to the L2/memory port through a valid/ready handshake.

Parameters:
- ENTRIES, 4, number of victim lines (power of two, ≥2).
- ADDR_W, 32, byte address width.
- LINE_W, 128, cache line width in bits.
- OFFSET_W, 4, line-offset bits; line tag = addr[ADDR_W-1:OFFSET_W].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- lookup_valid_i  in  1  L1 miss lookup request, one-cycle pulse.
- lookup_addr_i  in  ADDR_W  lookup byte address.
- swap_valid_o  out  1  lookup hit; line returned.
- swap_addr_o  out  ADDR_W  hit line address, offset bits zero.
- swap_data_o  out  LINE_W  hit line data.
- swap_dirty_o  out  1  hit line dirty flag.
- lookup_miss_o  out  1  lookup missed.
- evict_valid_i  in  1  L1 victim line offered.
- evict_addr_i  in  ADDR_W  victim address; offset ignored.
- evict_data_i  in  LINE_W  victim line data.
- evict_dirty_i  in  1  victim dirty flag.
- evict_ready_o  out  1  insert accepted this cycle.
- wb_valid_o  out  1  write-back request to memory.
- wb_addr_o  out  ADDR_W  write-back line address, offset zero.
- wb_data_o  out  LINE_W  write-back data.
- wb_ready_i  in  1  memory accepted the write-back.
- occupancy_o  out  $clog2(ENTRIES)+1  number of valid entries.
- no_lookup_o  out  32  lookup count.
- no_hit_o  out  32  hit count.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - All entries invalid; FIFO pointer = 0; wb FSM = IDLE.
  - All outputs 0 except evict_ready_o=1.
  - Counters = 0.
  - A pending write-back is discarded.
- Storage: per entry valid, dirty, tag, data.
  - Invariant: at most one valid entry per tag.
  - Lookups and inserts both operate on the pre-edge state.
- Lookup, latency 1:
  - Tag-compare lookup_addr_i against all valid entries.
  - On hit: next cycle swap_valid_o=1 for exactly one cycle, with that entry's address, data and dirty flag. The entry is invalidated at the same edge (line moves to L1).
  - On miss: next cycle lookup_miss_o=1 for one cycle, with swap_* = 0.
  - When no response is due, swap_* and lookup_miss_o are 0.
  - no_lookup_o increments per lookup_valid_i; no_hit_o increments per hit. Both are 32-bit and wrap.
- Insert happens on evict_valid_i & evict_ready_o. Slot priority:
  1. Entry with the same tag: overwrite data; dirty = old dirty | evict_dirty_i.
  2. Otherwise the lowest-index free entry. An entry freed by a lookup hit in the same cycle counts as free.
  3. Otherwise (full): replace the entry at the FIFO pointer, then pointer = (pointer+1) mod ENTRIES.
     - Displaced clean entry: dropped silently.
     - Displaced dirty entry: copied into the write-back register; wb FSM goes to WB_PEND.
- Write-back FSM, states IDLE and WB_PEND:
  - IDLE: wb_valid_o=0, evict_ready_o=1.
  - WB_PEND: wb_valid_o=1; wb_addr_o and wb_data_o held stable; evict_ready_o=0.
  - WB_PEND → IDLE on the edge where wb_ready_i=1. evict_ready_o=1 in the following cycle.
  - Lookups continue to be served in WB_PEND.
  - wb_valid_o never drops without wb_ready_i.
- Simultaneous events:
  - A lookup and an insert of the same tag in one cycle: the lookup misses (pre-edge state), and the insert lands.
  - Lookup hit plus insert while full: the insert takes the freed slot; no replacement and no write-back.
  - evict_valid_i while evict_ready_o=0: ignored. The producer must hold the line.
- occupancy_o is registered and reflects post-edge valid count.

Test Plan:
- Reset, then insert lines 0x1000, 0x2000 (clean) → occupancy_o=2; lookup 0x2004 → next cycle swap_valid_o=1, swap_addr_o=0x2000, swap_dirty_o=0; occupancy_o=1; no_hit_o=1.
- Lookup 0x3000 on non-matching contents → one-cycle lookup_miss_o=1, swap_valid_o=0; no_lookup_o increments, no_hit_o unchanged.
- Fill 4 entries (0x1000 dirty, rest clean), insert 0x5000 → wb_valid_o=1, wb_addr_o=0x1000, evict_ready_o=0; hold wb_ready_i=0 3 cycles (outputs stable), then pulse it → IDLE, evict_ready_o=1 next cycle; pointer=1.
- Full, clean entry at pointer, insert 0x6000 → no wb_valid_o; the pointer entry is replaced; occupancy_o stays 4.
- Full; same cycle: lookup hit on entry 2 and insert 0x7000 → swap of entry 2; 0x7000 stored in slot 2; no write-back; pointer unchanged.
- Assert rst_i during WB_PEND → next cycle wb_valid_o=0, occupancy_o=0, evict_ready_o=1, counters 0.
